// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller: FSM encoding, vector defaults,
// index-width and vector-address functions.
package intc_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } intc_state_e;

    localparam logic [7:0]  DefVecBase   = 8'hF0;
    localparam int unsigned DefVecStride = 4;

    function automatic int unsigned idx_w(int unsigned num_irq);
        return $clog2(num_irq);
    endfunction

    // Vector address wraps modulo 256.
    function automatic logic [7:0] vec_addr(logic [7:0] base, int unsigned stride,
                                            int unsigned idx);
        logic [31:0] sum;
        sum = 32'(base) + stride * idx;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/intc_if.sv
// Interrupt interface between the controller (master) and the processor side (slave).
interface intc_if
    import intc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
);
    localparam int unsigned IdxW = idx_w(NUM_IRQ);

    logic [NUM_IRQ-1:0] irq_in;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               int_ack;
    logic               rti_signal;
    logic               interrupt_signal;
    logic [7:0]         interrupt_vector_addr;
    logic [IdxW-1:0]    active_irq;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending_out;

    modport master (
        input  irq_in, mask_we, mask_wdata, int_ack, rti_signal,
        output interrupt_signal, interrupt_vector_addr, active_irq, in_service, pending_out
    );

    modport slave (
        output irq_in, mask_we, mask_wdata, int_ack, rti_signal,
        input  interrupt_signal, interrupt_vector_addr, active_irq, in_service, pending_out
    );

endinterface

// File: rtl/intc_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is eligible and the lowest set index.
module intc_priority_encoder #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    eligible_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching, masked, fixed-priority, non-nesting interrupt requester toward the PC.
// Define INTC_SYNC_EN to insert a 2-flop synchronizer on irq_in ahead of edge detection.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned          NUM_IRQ    = 4,
    parameter logic [7:0]           VEC_BASE   = DefVecBase,
    parameter int unsigned          VEC_STRIDE = DefVecStride,
    parameter logic [NUM_IRQ-1:0]   MASK_RESET = '1
) (
    input logic   clk,
    input logic   reset,
    intc_if.master bus
);

    localparam int unsigned IdxW = idx_w(NUM_IRQ);

    intc_state_e        state_q, state_d;
    logic [NUM_IRQ-1:0] irq_src, irq_prev_q, rise, eligible;
    logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d;
    logic               int_q, int_d, in_svc_q, in_svc_d;
    logic [7:0]         vec_q, vec_d;
    logic [IdxW-1:0]    active_q, active_d, sel_idx;
    logic               sel_valid;

`ifdef INTC_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_src = sync2_q;
`else
    assign irq_src = bus.irq_in;
`endif

    // irq_prev resets to 0 so a line already high at reset release counts as one event.
    assign rise     = irq_src & ~irq_prev_q;
    assign eligible = pending_q & mask_q;

    intc_priority_encoder #(
        .N    (NUM_IRQ),
        .IdxW (IdxW)
    ) u_prio (
        .eligible_i (eligible),
        .valid_o    (sel_valid),
        .idx_o      (sel_idx)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        int_d     = int_q;
        vec_d     = vec_q;
        active_d  = active_q;
        in_svc_d  = in_svc_q;
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;

        unique case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    active_d = sel_idx;
                    vec_d    = vec_addr(VEC_BASE, VEC_STRIDE, 32'(sel_idx));
                    int_d    = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // int_ack has priority over a coincident rti_signal.
                if (bus.int_ack) begin
                    pending_d[active_q] = 1'b0;
                    int_d               = 1'b0;
                    in_svc_d            = 1'b1;
                    state_d             = StService;
                end
            end
            StService: begin
                if (bus.rti_signal) begin
                    in_svc_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new edge wins over the acknowledge clear.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= MASK_RESET;
            int_q      <= 1'b0;
            vec_q      <= 8'h00;
            active_q   <= '0;
            in_svc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_src;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_q      <= int_d;
            vec_q      <= vec_d;
            active_q   <= active_d;
            in_svc_q   <= in_svc_d;
        end
    end

    assign bus.interrupt_signal      = int_q;
    assign bus.interrupt_vector_addr = vec_q;
    assign bus.active_irq            = active_q;
    assign bus.in_service            = in_svc_q;
    assign bus.pending_out           = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic against a
// behavioural model of the request/service protocol.
module tb_interrupt_controller;

`ifdef INTC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    intc_if #(.NUM_IRQ(4)) bus ();

    interrupt_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: which line is being requested / served, and the latched events.
    logic [3:0] m_prev, m_pend, m_mask, m_s1, m_s2;
    bit         m_req, m_srv;
    int         m_idx;
    logic [7:0] m_vec;

    task automatic model_reset();
        m_prev = 4'h0; m_pend = 4'h0; m_mask = 4'hF; m_s1 = 4'h0; m_s2 = 4'h0;
        m_req = 1'b0; m_srv = 1'b0; m_idx = 0; m_vec = 8'h00;
    endtask

    task automatic model_step();
        logic [3:0] src, rise, np;
        bit         nreq, nsrv, found;
        int         nidx;
        logic [7:0] nvec;
        src   = (SYNC_LAT != 0) ? m_s2 : bus.irq_in;
        rise  = src & ~m_prev;
        np    = m_pend;
        nreq  = m_req; nsrv = m_srv; nidx = m_idx; nvec = m_vec;
        found = 1'b0;
        if (m_req) begin
            if (bus.int_ack) begin
                np[m_idx] = 1'b0; nreq = 1'b0; nsrv = 1'b1;
            end
        end else if (m_srv) begin
            if (bus.rti_signal) nsrv = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!found && m_pend[i] && m_mask[i]) begin
                    found = 1'b1; nidx = i;
                end
            end
            if (found) begin
                nreq = 1'b1;
                nvec = 8'((240 + 4 * nidx) % 256);
            end
        end
        m_pend = np | rise;
        m_prev = src;
        m_s2   = m_s1;
        m_s1   = bus.irq_in;
        if (bus.mask_we) m_mask = bus.mask_wdata;
        m_req = nreq; m_srv = nsrv; m_idx = nidx; m_vec = nvec;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        bus.irq_in = 4'h0; bus.mask_we = 1'b0; bus.mask_wdata = 4'h0;
        bus.int_ack = 1'b0; bus.rti_signal = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic pulse_ack();
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
    endtask

    task automatic pulse_rti();
        bus.rti_signal = 1'b1; tick(); bus.rti_signal = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.interrupt_signal !== 1'b0 || bus.in_service !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got int=%b svc=%b want 0 0",
                     bus.interrupt_signal, bus.in_service);
        end
        checks++;
        if (bus.interrupt_vector_addr !== 8'h00 || bus.active_irq !== 2'd0) begin
            errors++;
            $display("FAIL reset_vec: got vec=%h idx=%0d want 00 0",
                     bus.interrupt_vector_addr, bus.active_irq);
        end
        checks++;
        if (bus.pending_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pending: got %b want 0000", bus.pending_out);
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.irq_in = 4'b0100;
        ticks(1 + SYNC_LAT);
        checks++;
        if (bus.pending_out !== 4'b0100 || bus.interrupt_signal !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: got pend=%b int=%b want 0100 0",
                     bus.pending_out, bus.interrupt_signal);
        end
        tick();
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hF8 ||
            bus.active_irq !== 2'd2) begin
            errors++;
            $display("FAIL single_req: got int=%b vec=%h idx=%0d want 1 F8 2",
                     bus.interrupt_signal, bus.interrupt_vector_addr, bus.active_irq);
        end
        pulse_ack();
        checks++;
        if (bus.in_service !== 1'b1 || bus.interrupt_signal !== 1'b0 ||
            bus.pending_out !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack: got svc=%b int=%b pend=%b want 1 0 0000",
                     bus.in_service, bus.interrupt_signal, bus.pending_out);
        end
        pulse_rti();
        checks++;
        if (bus.in_service !== 1'b0) begin
            errors++;
            $display("FAIL single_rti: got svc=%b want 0", bus.in_service);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        bus.irq_in = 4'b1010;
        ticks(2 + SYNC_LAT);
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hF4) begin
            errors++;
            $display("FAIL prio_first: got int=%b vec=%h want 1 F4",
                     bus.interrupt_signal, bus.interrupt_vector_addr);
        end
        pulse_ack();
        pulse_rti();
        checks++;
        if (bus.interrupt_signal !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle_gap: got int=%b want 0", bus.interrupt_signal);
        end
        tick();
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hFC ||
            bus.active_irq !== 2'd3 || bus.pending_out !== 4'b1000) begin
            errors++;
            $display("FAIL prio_second: got int=%b vec=%h idx=%0d pend=%b want 1 FC 3 1000",
                     bus.interrupt_signal, bus.interrupt_vector_addr, bus.active_irq,
                     bus.pending_out);
        end
        pulse_ack();
        pulse_rti();
    endtask

    task automatic test_mask();
        apply_reset();
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1110; tick(); bus.mask_we = 1'b0;
        bus.irq_in = 4'b0001;
        ticks(1 + SYNC_LAT);
        bus.irq_in = 4'b0000;
        ticks(3);
        checks++;
        if (bus.interrupt_signal !== 1'b0 || bus.pending_out !== 4'b0001) begin
            errors++;
            $display("FAIL mask_block: got int=%b pend=%b want 0 0001",
                     bus.interrupt_signal, bus.pending_out);
        end
        bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111; tick(); bus.mask_we = 1'b0;
        checks++;
        if (bus.interrupt_signal !== 1'b0) begin
            errors++;
            $display("FAIL mask_old_used: got int=%b want 0", bus.interrupt_signal);
        end
        tick();
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hF0) begin
            errors++;
            $display("FAIL mask_unblock: got int=%b vec=%h want 1 F0",
                     bus.interrupt_signal, bus.interrupt_vector_addr);
        end
    endtask

    task automatic test_service_block();
        apply_reset();
        bus.irq_in = 4'b0100;
        ticks(2 + SYNC_LAT);
        pulse_ack();
        bus.irq_in = 4'b0101;
        ticks(3 + SYNC_LAT);
        checks++;
        if (bus.interrupt_signal !== 1'b0 || bus.pending_out !== 4'b0001 ||
            bus.in_service !== 1'b1) begin
            errors++;
            $display("FAIL svc_hold: got int=%b pend=%b svc=%b want 0 0001 1",
                     bus.interrupt_signal, bus.pending_out, bus.in_service);
        end
        pulse_rti();
        checks++;
        if (bus.interrupt_signal !== 1'b0 || bus.in_service !== 1'b0) begin
            errors++;
            $display("FAIL svc_return: got int=%b svc=%b want 0 0",
                     bus.interrupt_signal, bus.in_service);
        end
        tick();
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hF0) begin
            errors++;
            $display("FAIL svc_next: got int=%b vec=%h want 1 F0",
                     bus.interrupt_signal, bus.interrupt_vector_addr);
        end
        bus.irq_in = 4'b0000;
    endtask

    task automatic test_held_and_ack_race();
        int reqs;
        bit last;
        apply_reset();
        reqs = 0; last = 1'b0;
        bus.irq_in = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.interrupt_signal && !last) reqs++;
            last = bus.interrupt_signal;
        end
        pulse_ack();
        pulse_rti();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.interrupt_signal && !last) reqs++;
            last = bus.interrupt_signal;
        end
        checks++;
        if (reqs !== 1 || bus.pending_out !== 4'b0000) begin
            errors++;
            $display("FAIL held_once: got reqs=%0d pend=%b want 1 0000", reqs, bus.pending_out);
        end
        // Rising edge on the active line lands in the same cycle as int_ack.
        apply_reset();
        bus.irq_in = 4'b0100;
        ticks(1 + SYNC_LAT);
        bus.irq_in = 4'b0000;
        ticks(1 + SYNC_LAT);
        bus.irq_in = 4'b0100;
        ticks(SYNC_LAT);
        pulse_ack();
        checks++;
        if (bus.in_service !== 1'b1 || bus.pending_out !== 4'b0100) begin
            errors++;
            $display("FAIL ack_race: got svc=%b pend=%b want 1 0100",
                     bus.in_service, bus.pending_out);
        end
        pulse_rti();
        tick();
        checks++;
        if (bus.interrupt_signal !== 1'b1 || bus.interrupt_vector_addr !== 8'hF8) begin
            errors++;
            $display("FAIL ack_race_again: got int=%b vec=%h want 1 F8",
                     bus.interrupt_signal, bus.interrupt_vector_addr);
        end
        bus.irq_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.irq_in = 4'b0100;
        ticks(2 + SYNC_LAT);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.interrupt_signal !== 1'b0 || bus.pending_out !== 4'b0000 ||
            bus.interrupt_vector_addr !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got int=%b pend=%b vec=%h want 0 0000 00",
                     bus.interrupt_signal, bus.pending_out, bus.interrupt_vector_addr);
        end
        bus.irq_in = 4'b0000;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) bus.irq_in[b] = ~bus.irq_in[b];
            end
            bus.int_ack    = ($urandom_range(0, 2) == 0);
            bus.rti_signal = ($urandom_range(0, 2) == 0);
            bus.mask_we    = ($urandom_range(0, 9) == 0);
            bus.mask_wdata = 4'($urandom);
            tick();
            checks++;
            if (bus.interrupt_signal !== m_req) begin
                errors++;
                $display("FAIL rnd_int c=%0d: got %b want %b", c, bus.interrupt_signal, m_req);
            end
            checks++;
            if (bus.interrupt_vector_addr !== m_vec) begin
                errors++;
                $display("FAIL rnd_vec c=%0d: got %h want %h", c, bus.interrupt_vector_addr,
                         m_vec);
            end
            checks++;
            if (bus.active_irq !== 2'(m_idx)) begin
                errors++;
                $display("FAIL rnd_idx c=%0d: got %0d want %0d", c, bus.active_irq, m_idx);
            end
            checks++;
            if (bus.in_service !== m_srv) begin
                errors++;
                $display("FAIL rnd_svc c=%0d: got %b want %b", c, bus.in_service, m_srv);
            end
            checks++;
            if (bus.pending_out !== m_pend) begin
                errors++;
                $display("FAIL rnd_pend c=%0d: got %b want %b", c, bus.pending_out, m_pend);
            end
        end
        bus.int_ack = 1'b0; bus.rti_signal = 1'b0; bus.mask_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_service_block();
        test_held_and_ack_race();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
